// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the CPU memory responder.
//   - state_t     : responder FSM states (IDLE/WAIT/ACK/HOLD, 2-bit encoding)
//   - CPU_ADDR_W  : width of the CPU address bus
//   - BYTE_W      : width of one memory byte
//   - parity()    : even-parity bit of a byte (XOR of all data bits)
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam int CPU_ADDR_W = 16;
   localparam int BYTE_W     = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2,
      HOLD = 2'd3
   } state_t;

   // Stored alongside the byte so the 9-bit word always has an even number of ones.
   function automatic logic parity(input logic [BYTE_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port synchronous RAM, 2**ADDR_W words of DATA_W bits.
// Ports:
//   clk    in   1       rising-edge clock
//   we     in   1       write enable: mem[addr] <= wdata
//   re     in   1       read enable:  rdata <= mem[addr]
//   addr   in   ADDR_W  word address
//   wdata  in   DATA_W  write data
//   rdata  out  DATA_W  registered read data, held until the next read
// Contents are never cleared; the array has no reset.
// -----------------------------------------------------------------------------
module mem_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/cpu_mem_responder.sv
// -----------------------------------------------------------------------------
// cpu_mem_responder
// Memory-side responder for the CPU memory port, with programmable wait
// states and a front-panel loader that writes the program image while the
// CPU is halted.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst        in   1       synchronous active-high reset
//   memaddr    in   16      CPU address
//   data_out   in   8       CPU write data
//   read       in   1       CPU read request, held until mem_ready
//   write      in   1       CPU write request, held until mem_ready
//   data_in    out  8       read data to the CPU, holds the last read byte
//   mem_ready  out  1       one-cycle completion pulse
//   mem_err    out  1       one-cycle error pulse, coincident with mem_ready
//   cpu_run    in   1       1: CPU owns memory, 0: loader owns memory
//   ld_en      in   1       loader write strobe
//   ld_addr    in   ADDR_W  loader address
//   ld_data    in   8       loader data
//
// Handshake: a request (read or write high) is sampled in IDLE while
// cpu_run=1. After WAIT_CYC wait states the operation executes on the edge
// that enters ACK, and mem_ready is high for the ACK cycle only. The FSM then
// sits in HOLD until the CPU drops both read and write, so a request that is
// held high is served exactly once.
//
// Build option: define MEM_PARITY_EN to store an even-parity bit per byte
// (written on CPU writes and loader writes) and flag a parity mismatch on
// read through mem_err.
// -----------------------------------------------------------------------------
module cpu_mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int WAIT_CYC = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CPU_ADDR_W-1:0] memaddr,
   input  logic [BYTE_W-1:0]     data_out,
   input  logic                  read,
   input  logic                  write,
   output logic [BYTE_W-1:0]     data_in,
   output logic                  mem_ready,
   output logic                  mem_err,
   input  logic                  cpu_run,
   input  logic                  ld_en,
   input  logic [ADDR_W-1:0]     ld_addr,
   input  logic [BYTE_W-1:0]     ld_data
);

`ifdef MEM_PARITY_EN
   localparam int MEM_W = BYTE_W + 1;
`else
   localparam int MEM_W = BYTE_W;
`endif

   // FSM and wait counter
   state_t      state;
   state_t      nxt;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nxt;

   // Request latches (valid outside IDLE)
   logic [CPU_ADDR_W-1:0] addr_q;
   logic [BYTE_W-1:0]     wdata_q;
   logic                  rd_q;
   logic                  wr_q;

   // Request currently being handled: live bus in IDLE, latched copy afterwards
   logic [CPU_ADDR_W-1:0] cur_addr;
   logic [BYTE_W-1:0]     cur_wdata;
   logic                  cur_rd;
   logic                  cur_wr;

   logic take;
   logic exec;
   logic oor;
   logic conflict;
   logic cpu_we;
   logic cpu_re;
   logic ld_we;

   // RAM port
   logic              ram_we;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_addr;
   logic [BYTE_W-1:0] ram_byte;
   logic [MEM_W-1:0]  ram_wdata;
   logic [MEM_W-1:0]  ram_rdata;

   // Read-data path: data_in comes from the RAM output register after an
   // in-range read, otherwise from hold_q (reset value or zero from an
   // out-of-range read).
   logic              src_ram_q;
   logic [BYTE_W-1:0] hold_q;
   logic              err_q;

`ifdef MEM_PARITY_EN
   logic chk_q;
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic and access decode
   // ---------------------------------------------------------------------------
   always_comb begin
      nxt       = state;
      cnt_nxt   = cnt;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_rd    = rd_q;
      cur_wr    = wr_q;

      if (state == IDLE) begin
         cur_addr  = memaddr;
         cur_wdata = data_out;
         cur_rd    = read;
         cur_wr    = write;
      end

      take = (state == IDLE) && cpu_run && (read || write);

      case (state)
         IDLE: begin
            if (take) begin
               if (WAIT_CYC == 0) begin
                  nxt = ACK;
               end else begin
                  nxt     = WAIT;
                  cnt_nxt = 4'(WAIT_CYC - 1);
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               nxt = ACK;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         ACK: begin
            nxt = HOLD;
         end
         HOLD: begin
            if (!read && !write) begin
               nxt = IDLE;
            end
         end
         default: begin
            nxt = IDLE;
         end
      endcase

      // The access happens on the edge that enters ACK; reset on that same
      // edge aborts it.
      exec     = (nxt == ACK) && !rst;
      oor      = (cur_addr >> ADDR_W) != '0;
      conflict = cur_rd && cur_wr;
      cpu_we   = exec && cur_wr && !cur_rd && !oor;
      cpu_re   = exec && cur_rd && !cur_wr && !oor;
      ld_we    = ld_en && !cpu_run && (state == IDLE) && !rst;

      // Loader and CPU never compete: the loader is live only with cpu_run=0,
      // when no CPU request can be accepted.
      ram_we   = ld_we || cpu_we;
      ram_re   = cpu_re;
      ram_addr = ld_we ? ld_addr : cur_addr[ADDR_W-1:0];
      ram_byte = ld_we ? ld_data : cur_wdata;
`ifdef MEM_PARITY_EN
      ram_wdata = {parity(ram_byte), ram_byte};
`else
      ram_wdata = ram_byte;
`endif
   end

   // ---------------------------------------------------------------------------
   // State, latches and response registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         err_q     <= 1'b0;
         src_ram_q <= 1'b0;
         hold_q    <= '0;
      end else begin
         state <= nxt;
         cnt   <= cnt_nxt;
         if (take) begin
            addr_q  <= memaddr;
            wdata_q <= data_out;
            rd_q    <= read;
            wr_q    <= write;
         end
         err_q <= exec && (oor || conflict);
         if (exec && cur_rd && !cur_wr) begin
            if (oor) begin
               hold_q    <= '0;
               src_ram_q <= 1'b0;
            end else begin
               src_ram_q <= 1'b1;
            end
         end
      end
   end

`ifdef MEM_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         chk_q <= 1'b0;
      end else begin
         chk_q <= cpu_re;
      end
   end
`endif

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (MEM_W)
   ) u_mem (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign mem_ready = (state == ACK);
   assign data_in   = src_ram_q ? ram_rdata[BYTE_W-1:0] : hold_q;

`ifdef MEM_PARITY_EN
   // A stored word with odd weight means the byte or its parity bit flipped.
   assign mem_err = err_q || (chk_q && (^ram_rdata));
`else
   assign mem_err = err_q;
`endif

endmodule
